// File: rtl/icache_refill_if.sv
// icache_refill_if: byte-wide memory read port shared through a req/grant arbiter.
interface icache_refill_if;
  logic memReq;
  logic memGrant;
  logic memReadEnable;
  logic [31:0] memAddrOut;
  logic [7:0] memByteIn;
  modport master(output memReq, memReadEnable, memAddrOut, input memGrant, memByteIn);
  modport slave(input memReq, memReadEnable, memAddrOut, output memGrant, memByteIn);
endinterface

// File: rtl/icache_refill.sv
// icache_refill: fetches a missing cache line byte-by-byte and hands it to the cache as one pulse.
module icache_refill #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE = 2**BLOCK_WIDTH
) (
  input  logic clkIn,
  input  logic resetIn,
  input  logic missIn,
  input  logic [31:0] missAddrIn,
  icache_refill_if.master mem,
  output logic lineValid,
  output logic [31-BLOCK_WIDTH:0] lineAddr,
  output logic [BLOCK_SIZE*8-1:0] lineData,
  output logic busy
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, FETCH = 2'd2, DONE = 2'd3;
  localparam logic [BLOCK_WIDTH:0] CNT_ONE = 1;
  localparam logic [BLOCK_WIDTH:0] CNT_FULL = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
  logic [1:0] state;
  logic [BLOCK_WIDTH:0] issueCnt, rxCnt;
  logic pending, issue;
  logic [BLOCK_SIZE-1:0][7:0] lineBytes;
  logic unusedLowBits;
  assign unusedLowBits = ^missAddrIn[BLOCK_WIDTH-1:0];
  assign issue = state == FETCH && mem.memGrant && issueCnt < CNT_FULL;
  assign mem.memReq = state == REQ || state == FETCH;
  assign mem.memReadEnable = issue;
  assign mem.memAddrOut = issue ? {lineAddr, issueCnt[BLOCK_WIDTH-1:0]} : '0;
  assign lineValid = state == DONE;
  assign busy = state != IDLE;
  assign lineData = lineBytes;
  // Data returns one cycle after its issue, so receive trails issue through the pending flag.
  always_ff @(posedge clkIn or negedge resetIn)
    if (!resetIn) begin
      state <= IDLE;
      issueCnt <= '0;
      rxCnt <= '0;
      pending <= 1'b0;
      lineAddr <= '0;
      lineBytes <= '0;
    end else
      case (state)
        IDLE: if (missIn) begin
          lineAddr <= missAddrIn[31:BLOCK_WIDTH];
          issueCnt <= '0;
          rxCnt <= '0;
          pending <= 1'b0;
          state <= REQ;
        end
        REQ: if (mem.memGrant) state <= FETCH;
        FETCH: begin
          issueCnt <= issue ? issueCnt + CNT_ONE : issueCnt;
          pending <= issue;
          if (pending) begin
            lineBytes[rxCnt[BLOCK_WIDTH-1:0]] <= mem.memByteIn;
            rxCnt <= rxCnt + CNT_ONE;
            if (rxCnt == CNT_FULL - CNT_ONE) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: scenario tasks plus randomized refills against a line-level reference model.
module tb_icache_refill;
  logic clkIn = 1'b0;
  logic resetIn = 1'b1;
  logic missIn = 1'b0;
  logic [31:0] missAddrIn = '0;
  logic lineValid, busy;
  logic [27:0] lineAddr;
  logic [127:0] lineData;
  icache_refill_if memIf();
  icache_refill dut(.clkIn(clkIn), .resetIn(resetIn), .missIn(missIn), .missAddrIn(missAddrIn),
                    .mem(memIf), .lineValid(lineValid), .lineAddr(lineAddr), .lineData(lineData), .busy(busy));
  always #5 clkIn = ~clkIn;
  int cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;
  int compared = 0, mismatched = 0, nRefills = 0;
  logic [7:0] mask = '0;
  function automatic logic [7:0] ramByte(input logic [31:0] a);
    return {4'hA, a[3:0]} ^ mask;
  endfunction
  // RAM model: data for a read issued in one cycle is presented throughout the next one.
  logic prevRd = 1'b0;
  logic [31:0] prevAddr = '0;
  always @(negedge clkIn) begin
    memIf.memByteIn = prevRd ? ramByte(prevAddr) : 8'($urandom);
    prevRd = memIf.memReadEnable;
    prevAddr = memIf.memAddrOut;
  end
  logic [31:0] rdAddr[$];
  int rdCyc[$];
  int lvCount = 0, badCnt = 0;
  always @(negedge clkIn) begin
    if (memIf.memReadEnable) begin
      rdAddr.push_back(memIf.memAddrOut);
      rdCyc.push_back(cyc);
    end
    if (lineValid) lvCount++;
    if ((memIf.memReadEnable && !memIf.memGrant) || (busy && !lineValid && !memIf.memReq) ||
        (lineValid && (memIf.memReq || memIf.memReadEnable)) ||
        (!busy && (memIf.memReq || memIf.memReadEnable || lineValid))) badCnt++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end
  task automatic doRefill(input logic [31:0] addr, input int reqDelay, stallAfter, stallLen, changeAt,
                          input logic [31:0] newAddr, input bit keepMiss, output int t0, output int vRel,
                          output logic [27:0] vAddr, output logic [127:0] vData, output logic busy0);
    int stallDone = 0;
    vRel = -1;
    vAddr = '0;
    vData = '0;
    @(posedge clkIn); #1;
    t0 = cyc;
    rdAddr.delete();
    rdCyc.delete();
    missIn = 1'b1;
    missAddrIn = addr;
    memIf.memGrant = 1'($urandom_range(0, 1));
    @(negedge clkIn);
    busy0 = busy;
    for (int i = 1; i < 80 && vRel < 0; i++) begin
      @(posedge clkIn); #1;
      if (!keepMiss) missIn = 1'b0;
      if (i == changeAt) missAddrIn = newAddr;
      if (i <= reqDelay) memIf.memGrant = 1'b0;
      else if (stallLen > 0 && rdAddr.size() == stallAfter && stallDone < stallLen) begin
        memIf.memGrant = 1'b0;
        stallDone++;
      end else memIf.memGrant = 1'b1;
      @(negedge clkIn);
      if (lineValid) begin
        vRel = i;
        vAddr = lineAddr;
        vData = lineData;
      end
    end
  endtask
  task automatic test_reset;
    #2 resetIn = 1'b0;
    #1;
    compared++; if (memIf.memReq !== 1'b0) begin mismatched++; $display("FAIL reset_memReq: got %b want 0", memIf.memReq); end
    compared++; if (memIf.memReadEnable !== 1'b0) begin mismatched++; $display("FAIL reset_rd: got %b want 0", memIf.memReadEnable); end
    compared++; if (memIf.memAddrOut !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", memIf.memAddrOut); end
    compared++; if (lineValid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL reset_flags: got valid=%b busy=%b want 0 0", lineValid, busy); end
    compared++; if (lineAddr !== 28'h0 || lineData !== 128'h0) begin mismatched++; $display("FAIL reset_line: got %h/%h want 0", lineAddr, lineData); end
    @(posedge clkIn); #3 resetIn = 1'b1;
    memIf.memGrant = 1'b1;
    repeat (3) @(negedge clkIn);
    compared++; if (busy !== 1'b0 || memIf.memReq !== 1'b0) begin mismatched++; $display("FAIL idle_grant: got busy=%b req=%b want 0 0", busy, memIf.memReq); end
  endtask
  task automatic test_basic;
    int t0, vRel; logic [27:0] vAddr; logic [127:0] vData, exp; logic b0;
    mask = 8'h00;
    doRefill(32'h0000_1234, 0, 0, 0, -1, 32'h0, 1'b0, t0, vRel, vAddr, vData, b0);
    nRefills++;
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = 8'hA0 + 8'(k);
    compared++; if (b0 !== 1'b0) begin mismatched++; $display("FAIL basic_idle: got busy=%b want 0", b0); end
    compared++; if (vRel !== 19) begin mismatched++; $display("FAIL basic_valid_cycle: got %0d want 19", vRel); end
    compared++; if (vAddr !== 28'h0000123) begin mismatched++; $display("FAIL basic_lineAddr: got %h want 0000123", vAddr); end
    compared++; if (vData[7:0] !== 8'hA0 || vData[127:120] !== 8'hAF) begin mismatched++; $display("FAIL basic_ends: got %h/%h want a0/af", vData[7:0], vData[127:120]); end
    compared++; if (vData !== exp) begin mismatched++; $display("FAIL basic_data: got %h want %h", vData, exp); end
    compared++; if (rdAddr.size() !== 16) begin mismatched++; $display("FAIL basic_nreads: got %0d want 16", rdAddr.size()); end
    for (int k = 0; k < 16 && k < rdAddr.size(); k++) begin
      compared++; if (rdAddr[k] !== 32'h1230 + 32'(k) || rdCyc[k] - t0 !== 2 + k) begin
        mismatched++; $display("FAIL basic_read%0d: got %h@%0d want %h@%0d", k, rdAddr[k], rdCyc[k] - t0, 32'h1230 + 32'(k), 2 + k);
      end
    end
  endtask
  task automatic test_grant_stall;
    int t0, vRel; logic [27:0] vAddr; logic [127:0] vData, exp; logic b0;
    mask = 8'h00;
    doRefill(32'h0000_1234, 0, 5, 3, -1, 32'h0, 1'b0, t0, vRel, vAddr, vData, b0);
    nRefills++;
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = 8'hA0 + 8'(k);
    compared++; if (vRel !== 22) begin mismatched++; $display("FAIL stall_valid_cycle: got %0d want 22", vRel); end
    compared++; if (vData !== exp) begin mismatched++; $display("FAIL stall_data: got %h want %h", vData, exp); end
    compared++; if (rdAddr.size() !== 16) begin mismatched++; $display("FAIL stall_nreads: got %0d want 16", rdAddr.size()); end
    for (int k = 0; k < 16 && k < rdAddr.size(); k++) begin
      compared++; if (rdAddr[k] !== 32'h1230 + 32'(k)) begin mismatched++; $display("FAIL stall_read%0d: got %h want %h", k, rdAddr[k], 32'h1230 + 32'(k)); end
    end
    if (rdCyc.size() > 5) begin
      compared++; if (rdCyc[5] - t0 !== 10) begin mismatched++; $display("FAIL stall_resume: got cycle %0d want 10", rdCyc[5] - t0); end
    end
  endtask
  task automatic test_late_grant;
    int t0, vRel; logic [27:0] vAddr; logic [127:0] vData; logic b0;
    int bad0;
    mask = 8'h3C;
    bad0 = badCnt;
    doRefill(32'h0000_1234, 10, 0, 0, -1, 32'h0, 1'b0, t0, vRel, vAddr, vData, b0);
    nRefills++;
    compared++; if (rdCyc.size() == 0 || rdCyc[0] - t0 !== 12) begin mismatched++; $display("FAIL late_first_cycle: got %0d want 12", rdCyc.size() ? rdCyc[0] - t0 : -1); end
    compared++; if (rdAddr.size() == 0 || rdAddr[0] !== 32'h1230) begin mismatched++; $display("FAIL late_first_addr: got %h want 00001230", rdAddr.size() ? rdAddr[0] : 32'hx); end
    compared++; if (vRel !== 29) begin mismatched++; $display("FAIL late_valid_cycle: got %0d want 29", vRel); end
    compared++; if (badCnt !== bad0) begin mismatched++; $display("FAIL late_protocol: got %0d violations want %0d", badCnt, bad0); end
  endtask
  task automatic test_addr_change;
    int t0, vRel; logic [27:0] vAddr; logic [127:0] vData; logic b0;
    int outside = 0;
    mask = 8'hC3;
    doRefill(32'h0000_1234, 0, 0, 0, 8, 32'h0000_5000, 1'b0, t0, vRel, vAddr, vData, b0);
    nRefills++;
    foreach (rdAddr[k]) if (rdAddr[k][31:4] !== 28'h0000123) outside++;
    compared++; if (outside !== 0 || rdAddr.size() !== 16) begin mismatched++; $display("FAIL chg_reads: got %0d outside of %0d want 0 of 16", outside, rdAddr.size()); end
    compared++; if (vAddr !== 28'h0000123) begin mismatched++; $display("FAIL chg_lineAddr: got %h want 0000123", vAddr); end
  endtask
  task automatic test_back_to_back;
    int t0a, t0b, vRel, vRel2; logic [27:0] vAddr; logic [127:0] vData, exp; logic b0;
    mask = 8'h69;
    doRefill(32'h0000_1234, 0, 0, 0, 10, 32'h0000_2000, 1'b1, t0a, vRel, vAddr, vData, b0);
    nRefills++;
    compared++; if (vAddr !== 28'h0000123 || vRel !== 19) begin mismatched++; $display("FAIL b2b_first: got %h@%0d want 0000123@19", vAddr, vRel); end
    doRefill(32'h0000_2000, 0, 0, 0, -1, 32'h0, 1'b0, t0b, vRel2, vAddr, vData, b0);
    nRefills++;
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = ramByte(32'h2000 + 32'(k));
    compared++; if (rdCyc.size() == 0 || rdCyc[0] - t0a !== 22) begin mismatched++; $display("FAIL b2b_first_read: got %0d want 22", rdCyc.size() ? rdCyc[0] - t0a : -1); end
    compared++; if (t0b + vRel2 - t0a !== 39) begin mismatched++; $display("FAIL b2b_valid_cycle: got %0d want 39", t0b + vRel2 - t0a); end
    compared++; if (vAddr !== 28'h0000200 || vData !== exp) begin mismatched++; $display("FAIL b2b_line: got %h/%h want 0000200/%h", vAddr, vData, exp); end
    for (int k = 0; k < 16 && k < rdAddr.size(); k++) begin
      compared++; if (rdAddr[k] !== 32'h2000 + 32'(k)) begin mismatched++; $display("FAIL b2b_read%0d: got %h want %h", k, rdAddr[k], 32'h2000 + 32'(k)); end
    end
  endtask
  task automatic test_reset_mid_fetch;
    int t0, vRel, lv0; logic [27:0] vAddr; logic [127:0] vData, exp; logic b0;
    mask = 8'h5A;
    @(posedge clkIn); #1;
    missIn = 1'b1;
    missAddrIn = 32'h0000_1234;
    memIf.memGrant = 1'b1;
    rdAddr.delete();
    rdCyc.delete();
    lv0 = lvCount;
    for (int i = 1; i <= 10; i++) begin @(posedge clkIn); #1; missIn = 1'b0; end
    #2 resetIn = 1'b0;
    #1;
    compared++; if (rdAddr.size() !== 8) begin mismatched++; $display("FAIL rst_reads_before: got %0d want 8", rdAddr.size()); end
    compared++; if (memIf.memReq !== 1'b0 || memIf.memReadEnable !== 1'b0) begin mismatched++; $display("FAIL rst_mem: got req=%b rd=%b want 0 0", memIf.memReq, memIf.memReadEnable); end
    compared++; if (lineValid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rst_flags: got valid=%b busy=%b want 0 0", lineValid, busy); end
    compared++; if (lineData !== 128'h0 || lineAddr !== 28'h0) begin mismatched++; $display("FAIL rst_line: got %h/%h want 0", lineAddr, lineData); end
    repeat (2) @(posedge clkIn);
    #1;
    compared++; if (lvCount !== lv0) begin mismatched++; $display("FAIL rst_no_pulse: got %0d pulses want %0d", lvCount, lv0); end
    #2 resetIn = 1'b1;
    doRefill(32'h0000_1234, 1, 3, 2, -1, 32'h0, 1'b0, t0, vRel, vAddr, vData, b0);
    nRefills++;
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = ramByte(32'h1230 + 32'(k));
    compared++; if (rdAddr.size() !== 16 || rdAddr[0] !== 32'h1230) begin mismatched++; $display("FAIL rst_restart: got %0d reads from %h want 16 from 00001230", rdAddr.size(), rdAddr.size() ? rdAddr[0] : 32'hx); end
    compared++; if (vRel !== 22 || vData !== exp) begin mismatched++; $display("FAIL rst_refill: got %h@%0d want %h@22", vData, vRel, exp); end
  endtask
  task automatic test_random;
    int t0, vRel, rd, sa, sl, ca; logic [27:0] vAddr; logic [127:0] vData, exp; logic b0;
    logic [31:0] a;
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      mask = 8'($urandom);
      rd = $urandom_range(0, 4);
      sa = $urandom_range(1, 15);
      sl = $urandom_range(0, 4);
      ca = $urandom_range(2, 15);
      doRefill(a, rd, sa, sl, ca, $urandom, 1'b0, t0, vRel, vAddr, vData, b0);
      nRefills++;
      for (int k = 0; k < 16; k++) exp[8*k +: 8] = ramByte({a[31:4], 4'(k)});
      compared++; if (vRel !== 19 + rd + sl) begin mismatched++; $display("FAIL rnd%0d_valid_cycle: got %0d want %0d", n, vRel, 19 + rd + sl); end
      compared++; if (vAddr !== a[31:4] || vData !== exp) begin mismatched++; $display("FAIL rnd%0d_line: got %h/%h want %h/%h", n, vAddr, vData, a[31:4], exp); end
      compared++; if (rdAddr.size() !== 16) begin mismatched++; $display("FAIL rnd%0d_nreads: got %0d want 16", n, rdAddr.size()); end
      for (int k = 0; k < 16 && k < rdAddr.size(); k++) begin
        compared++; if (rdAddr[k] !== {a[31:4], 4'(k)}) begin mismatched++; $display("FAIL rnd%0d_read%0d: got %h want %h", n, k, rdAddr[k], {a[31:4], 4'(k)}); end
      end
    end
  endtask
  initial begin
    memIf.memGrant = 1'b0;
    test_reset;
    test_basic;
    test_grant_stall;
    test_late_grant;
    test_addr_change;
    test_back_to_back;
    test_reset_mid_fetch;
    test_random;
    @(posedge clkIn); #1;
    compared++; if (lvCount !== nRefills) begin mismatched++; $display("FAIL pulse_count: got %0d want %0d", lvCount, nRefills); end
    compared++; if (badCnt !== 0) begin mismatched++; $display("FAIL protocol: got %0d violations want 0", badCnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
